// File: rtl/fifo_frame_reader.sv
// Drains a show-ahead byte FIFO and parses SYNC/CMD/payload/XOR-checksum frames,
// presenting validated commands on a valid/ready handshake.
module fifo_frame_reader #(
    parameter int unsigned  B         = 8,
    parameter int unsigned  N_PAYLOAD = 4,
    parameter logic [B-1:0] SYNC      = 8'hA5,
    parameter int unsigned  TIMEOUT   = 50000,
    parameter int unsigned  TW        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [B-1:0]           fifo_r_data,
    output logic                   fifo_rd,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [B-1:0]           cmd_code,
    output logic [B*N_PAYLOAD-1:0] cmd_data,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int unsigned CW = (N_PAYLOAD > 1) ? $clog2(N_PAYLOAD) : 1;

    typedef enum logic [2:0] {StHunt, StCmd, StPayload, StCheck, StOut} state_t;

    state_t                 state;
    logic [B-1:0]           csum;
    logic [CW-1:0]          byte_cnt;
    logic [TW-1:0]          tcount;
    logic [B*N_PAYLOAD-1:0] data_next;
    logic                   in_frame;
    logic                   timed_out;

    // OUT is the only state that never pops; this is what stalls the FIFO.
    assign fifo_rd   = ~fifo_empty & ~reset & (state != StOut);
    assign busy      = (state != StHunt);
    assign in_frame  = (state == StCmd) || (state == StPayload) || (state == StCheck);
    assign timed_out = in_frame & fifo_empty & (tcount == TW'(TIMEOUT - 1));

    generate
        if (N_PAYLOAD > 1) begin : g_shift
            assign data_next = {cmd_data[B*(N_PAYLOAD-1)-1:0], fifo_r_data};
        end else begin : g_single
            assign data_next = fifo_r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StHunt;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            cmd_code  <= '0;
            cmd_data  <= '0;
            csum      <= '0;
            byte_cnt  <= '0;
            tcount    <= '0;
        end else begin
            frame_err <= 1'b0;

            // A pop in the expiring cycle wins over the timeout.
            if (in_frame) begin
                if (fifo_rd) begin
                    tcount <= '0;
                end else if (timed_out) begin
                    tcount    <= '0;
                    state     <= StHunt;
                    frame_err <= 1'b1;
                    err_code  <= 2'b10;
                end else begin
                    tcount <= tcount + TW'(1);
                end
            end

            unique case (state)
                StHunt: begin
                    if (fifo_rd && fifo_r_data == SYNC) begin
                        state    <= StCmd;
                        csum     <= '0;
                        byte_cnt <= '0;
                        tcount   <= '0;
                    end
                end
                StCmd: begin
                    if (fifo_rd) begin
                        cmd_code <= fifo_r_data;
                        csum     <= fifo_r_data;
                        byte_cnt <= '0;
                        state    <= StPayload;
                    end
                end
                StPayload: begin
                    if (fifo_rd) begin
                        cmd_data <= data_next;
                        csum     <= csum ^ fifo_r_data;
                        byte_cnt <= byte_cnt + CW'(1);
                        if (byte_cnt == CW'(N_PAYLOAD - 1)) begin
                            state <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (fifo_rd) begin
                        if (fifo_r_data == csum) begin
                            cmd_valid <= 1'b1;
                            state     <= StOut;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b01;
                            state     <= StHunt;
                        end
                    end
                end
                StOut: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= StHunt;
                    end
                end
                default: state <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with a queue-based show-ahead FIFO model.
module tb_fifo_frame_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_r_data;
    logic        fifo_rd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    logic        last_rd;
    logic [7:0]  fq[$];

    always #5 clk = ~clk;

    fifo_frame_reader #(
        .B(8), .N_PAYLOAD(4), .SYNC(8'hA5), .TIMEOUT(16), .TW(16)
    ) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
        .fifo_rd(fifo_rd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_data(cmd_data), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    task automatic drive();
        fifo_empty  = (fq.size() == 0);
        fifo_r_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        drive();
    endtask

    task automatic push_good();
        push(8'hA5); push(8'h01); push(8'h12); push(8'h34);
        push(8'h56); push(8'h78); push(8'h09);
    endtask

    // One clock: sample fifo_rd mid-cycle, pop the model after the edge.
    task automatic tick();
        @(negedge clk);
        last_rd = fifo_rd;
        checks++;
        if ((fifo_rd & fifo_empty) !== 1'b0) begin
            errors++;
            $display("FAIL rd_while_empty: fifo_rd=%b fifo_empty=%b required no pop", fifo_rd,
                     fifo_empty);
        end
        @(posedge clk);
        #1;
        if (last_rd) void'(fq.pop_front());
        drive();
        if (frame_err === 1'b1) err_pulses++;
    endtask

    task automatic expect_cmd(input string name, input logic [7:0] code, input logic [31:0] data);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== code || cmd_data !== data) begin
            errors++;
            $display("FAIL %s: valid=%b code=%h data=%h required 1 %h %h", name, cmd_valid,
                     cmd_code, cmd_data, code, data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_ready = 1'b1;
        drive();
        tick();
        tick();
        checks++;
        if ({cmd_valid, frame_err, err_code, cmd_code, cmd_data, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b e=%b c=%b code=%h data=%h busy=%b required all 0",
                     cmd_valid, frame_err, err_code, cmd_code, cmd_data, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_good_frame();
        int rd_cnt = 0;
        int e0 = err_pulses;
        push_good();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL good_early_valid: cycle %0d valid=%b required 0", i, cmd_valid);
            end
            tick();
            rd_cnt += int'(last_rd);
        end
        checks++;
        if (rd_cnt !== 7) begin
            errors++;
            $display("FAIL good_pops: got %0d required 7", rd_cnt);
        end
        expect_cmd("good_cmd", 8'h01, 32'h12345678);
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || err_pulses !== e0) begin
            errors++;
            $display("FAIL good_handshake: valid=%b errs=%0d required 0 %0d", cmd_valid,
                     err_pulses, e0);
        end
    endtask

    task automatic test_garbage_resync();
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h02); push(8'hAA);
        push(8'hBB); push(8'hCC); push(8'hDD); push(8'h02);
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL garbage_busy: got %b required 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL garbage_sync_busy: got %b required 1", busy);
        end
        for (int i = 0; i < 6; i++) tick();
        expect_cmd("garbage_cmd", 8'h02, 32'hAABBCCDD);
        tick();
    endtask

    task automatic test_bad_checksum();
        push(8'hA5); push(8'h01); push(8'h12); push(8'h34);
        push(8'h56); push(8'h78); push(8'h0A);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'b01 || cmd_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum: err=%b code=%b valid=%b busy=%b required 1 01 0 0",
                     frame_err, err_code, cmd_valid, busy);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0 || err_code !== 2'b01) begin
            errors++;
            $display("FAIL bad_csum_pulse: err=%b code=%b required 0 01", frame_err, err_code);
        end
        push_good();
        for (int i = 0; i < 7; i++) tick();
        expect_cmd("after_bad_cmd", 8'h01, 32'h12345678);
        tick();
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        cmd_ready = 1'b0;
        push_good();
        push(8'hA5); push(8'h03); push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF); push(8'h21);
        for (int i = 0; i < 7; i++) tick();
        expect_cmd("bp_first", 8'h01, 32'h12345678);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_rd !== 1'b0 || cmd_valid !== 1'b1 || cmd_data !== 32'h12345678) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_stall: %0d bad cycles required 0", bad);
        end
        checks++;
        if (fq.size() !== 7) begin
            errors++;
            $display("FAIL bp_fifo_level: got %0d required 7", fq.size());
        end
        cmd_ready = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || last_rd !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b rd=%b required 0 0", cmd_valid, last_rd);
        end
        for (int i = 0; i < 7; i++) tick();
        expect_cmd("bp_second", 8'h03, 32'hDEADBEEF);
        tick();
    endtask

    task automatic test_timeout();
        push(8'hA5); push(8'h01); push(8'h12);
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: err=%b busy=%b required 0 1", frame_err, busy);
        end
        tick();
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_expire: err=%b code=%b busy=%b required 1 10 0", frame_err,
                     err_code, busy);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_width: err=%b required 0", frame_err);
        end
        // Byte lands exactly on the expiring cycle: pop wins.
        push(8'hA5); push(8'h01); push(8'h12);
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 15; i++) tick();
        push(8'h34);
        tick();
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1 || last_rd !== 1'b1) begin
            errors++;
            $display("FAIL to_rescue: err=%b busy=%b rd=%b required 0 1 1", frame_err, busy,
                     last_rd);
        end
        push(8'h56); push(8'h78); push(8'h09);
        for (int i = 0; i < 3; i++) tick();
        expect_cmd("to_rescued_cmd", 8'h01, 32'h12345678);
        checks++;
        if (err_code !== 2'b10) begin
            errors++;
            $display("FAIL to_code_held: got %b required 10", err_code);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        push(8'hA5); push(8'h01); push(8'h12);
        for (int i = 0; i < 3; i++) tick();
        push_good();
        e0 = err_pulses;
        reset = 1'b1;
        tick();
        checks++;
        if (last_rd !== 1'b0 || {cmd_valid, frame_err, err_code, cmd_code, cmd_data, busy} !== '0)
        begin
            errors++;
            $display("FAIL mid_reset: rd=%b v=%b e=%b c=%b code=%h data=%h busy=%b required 0",
                     last_rd, cmd_valid, frame_err, err_code, cmd_code, cmd_data, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        expect_cmd("mid_reset_cmd", 8'h01, 32'h12345678);
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("FAIL mid_reset_err: pulses %0d required %0d", err_pulses, e0);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_garbage_resync();
        test_bad_checksum();
        test_back_pressure();
        test_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
